float_to_fixed_conv: RTL

Multi-cycle converter from IEEE-754 single-precision to signed two's-complement fixed point. It carries results from the floating-point add/sub datapath into the fixed-point domain used by activation lookup and output thresholding in the XOR network. The converter aligns the mantissa iteratively, one bit per cycle, instead of using a barrel shifter. It uses valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp32_unpack.sv | 19 +
 rtl/float_to_fixed_conv.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout and the float-to-fixed converter state types.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_INF  = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_DONE
    } conv_state_t;

    typedef enum logic [1:0] {
        RES_NORM,
        RES_ZERO,
        RES_SAT
    } res_kind_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational field decode of an IEEE-754 single; denormals are reported as zero (flush).
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0]     data,
    output logic            sign,
    output logic [7:0]      exponent,
    output logic [FRAC_W:0] mant,
    output logic            is_zero,
    output logic            is_special
);

    assign sign       = data[SIGN_BIT];
    assign exponent   = data[EXP_MSB:EXP_LSB];
    assign is_zero    = (exponent == 8'd0);
    assign is_special = (exponent == 8'(EXP_INF));
    assign mant       = {~is_zero, data[FRAC_W-1:0]};

endmodule

// File: rtl/float_to_fixed_conv.sv
// IEEE-754 single to signed fixed-point converter with bit-serial mantissa alignment.
// Optional round-half-away-from-zero on right shifts when F2X_ROUND_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for an input handshake
// ST_ALIGN | shift magnitude one bit per cycle until count hits zero
// ST_DONE  | out_valid high, out_data held until out_ready
module float_to_fixed_conv
    import fp_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int CNT_W      = 6;
    localparam int SH_MAX     = OUT_W - 25;
    localparam int SH_MIN     = -24;
    localparam int ALIGN_BIAS = EXP_BIAS + FRAC_W;

    conv_state_t state, state_nxt;
    res_kind_t   kind_r;
    logic             sign_r;
    logic             left_r;
    logic [CNT_W-1:0] cnt_r;
    logic [OUT_W-1:0] mag_r;
    logic [OUT_W-1:0] mag_fin;
    logic [OUT_W-1:0] result;

    logic            u_sign;
    logic [7:0]      u_exp;
    logic [FRAC_W:0] u_mant;
    logic            u_zero;
    logic            u_special;

    int  sh;
    int  sh_abs;
    logic accept;

    fp32_unpack u_unpack (
        .data       (in_data),
        .sign       (u_sign),
        .exponent   (u_exp),
        .mant       (u_mant),
        .is_zero    (u_zero),
        .is_special (u_special)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sh     = int'(u_exp) - ALIGN_BIAS + FRAC_BITS;
        sh_abs = (sh < 0) ? -sh : sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ALIGN;
            ST_ALIGN: if (cnt_r == '0) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

`ifdef F2X_ROUND_EN
    logic guard_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            guard_r <= 1'b0;
        end else if (state == ST_IDLE && accept) begin
            guard_r <= 1'b0;
        end else if (state == ST_ALIGN && cnt_r != '0 && !left_r) begin
            guard_r <= mag_r[0];
        end
    end

    assign mag_fin = mag_r + OUT_W'(guard_r);
`else
    assign mag_fin = mag_r;
`endif

    always_comb begin
        result = '0;
        case (kind_r)
            RES_NORM: result = sign_r ? (-mag_fin) : mag_fin;
            RES_SAT:  result = sign_r ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
            default:  result = '0;
        endcase
    end

    // Special cases load a zero count so they finalize after one ALIGN cycle,
    // giving them the same latency as an exact (|sh| == 0) conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_r   <= RES_NORM;
            sign_r   <= 1'b0;
            left_r   <= 1'b0;
            cnt_r    <= '0;
            mag_r    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_r <= u_sign;
                        left_r <= (sh > 0);
                        mag_r  <= OUT_W'(u_mant);
                        if (u_zero || sh < SH_MIN) begin
                            kind_r <= RES_ZERO;
                            cnt_r  <= '0;
                        end else if (u_special || sh > SH_MAX) begin
                            kind_r <= RES_SAT;
                            cnt_r  <= '0;
                        end else begin
                            kind_r <= RES_NORM;
                            cnt_r  <= CNT_W'(sh_abs);
                        end
                    end
                end
                ST_ALIGN: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        mag_r <= left_r ? (mag_r << 1) : (mag_r >> 1);
                    end else begin
                        out_data <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
